// File: rtl/sw_axis.sv
// sw_axis
//
// Debounces the eight board slide switches and publishes every new stable
// switch pattern as one byte on an AXI-Stream master port. A small output
// FIFO absorbs events while the consumer is busy. Events that arrive while
// the FIFO is full are dropped, and a sticky flag records the drop.
//
// Ports
//   clk_i            system clock
//   rst_i            asynchronous, active-high reset
//   sw_i[7:0]        raw slide switches (asynchronous to clk_i)
//   m_axis_tready_i  consumer ready
//   m_axis_tvalid_o  FIFO head is valid
//   m_axis_tdata_o   FIFO head byte (switch pattern)
//   clr_ovf_i        synchronous clear of overflow_o
//   overflow_o       sticky flag, set when an event is dropped
//
// Parameters
//   DEBOUNCE_CYCLES  cycles a new pattern must hold before acceptance (>= 2)
//   FIFO_DEPTH       output FIFO entries (power of 2, >= 2)

module sw_axis #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] sw_i,
  input  logic       m_axis_tready_i,
  output logic       m_axis_tvalid_o,
  output logic [7:0] m_axis_tdata_o,
  input  logic       clr_ovf_i,
  output logic       overflow_o
);

  localparam int CntW = $clog2(DEBOUNCE_CYCLES);
  localparam int PtrW = $clog2(FIFO_DEPTH);

  logic [7:0]      sync1_q, sync2_q;
  logic [7:0]      cand_q, cand_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [7:0]      stable_q, stable_d;
  logic [7:0]      prevStable_q;
  logic            push_q;

  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [PtrW-1:0] wrPtr_q, rdPtr_q;
  logic [PtrW:0]   count_q;
  logic            overflow_q;

  logic            full, pop, doWrite, dropEvent;

  // The switches are asynchronous to clk_i. Two flops in series bring them
  // safely into the clock domain before any logic looks at them.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q <= 8'h00;
      sync2_q <= 8'h00;
    end else begin
      sync1_q <= sw_i;
      sync2_q <= sync1_q;
    end
  end

  // Debounce treats the byte as a whole. Any bit that differs from the
  // candidate restarts the count. Once the candidate has held for the full
  // window it becomes the stable pattern. The counter then parks at its
  // terminal value, so stable keeps reloading the same value, which has no
  // effect.
  always_comb begin
    cand_d   = cand_q;
    cnt_d    = cnt_q;
    stable_d = stable_q;
    if (sync2_q != cand_q) begin
      cand_d = sync2_q;
      cnt_d  = '0;
    end else if (cnt_q == CntW'(DEBOUNCE_CYCLES - 1)) begin
      stable_d = cand_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cand_q   <= 8'h00;
      cnt_q    <= '0;
      stable_q <= 8'h00;
    end else begin
      cand_q   <= cand_d;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end

  // Change detect compares stable against a one-cycle-delayed copy. The
  // result is a registered pulse on the cycle after stable moves. stable
  // cannot move again for at least DEBOUNCE_CYCLES cycles, so stable_q still
  // holds the new pattern when the FIFO writes it.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      prevStable_q <= 8'h00;
      push_q       <= 1'b0;
    end else begin
      prevStable_q <= stable_q;
      push_q       <= (stable_q != prevStable_q);
    end
  end

  assign full      = (count_q == (PtrW + 1)'(FIFO_DEPTH));
  assign pop       = m_axis_tvalid_o & m_axis_tready_i;
  // A push into a full FIFO is still accepted when the head leaves in the
  // same cycle. The freed slot is exactly the one the write pointer names.
  assign doWrite   = push_q & (~full | pop);
  assign dropEvent = push_q & full & ~pop;

  // FIFO storage and pointers. The entries are reset as well, so that the
  // head byte reads 0x00 after reset, not stale data.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= 8'h00;
      end
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (doWrite) begin
        mem_q[wrPtr_q] <= stable_q;
        wrPtr_q        <= wrPtr_q + 1'b1;
      end
      if (pop) begin
        rdPtr_q <= rdPtr_q + 1'b1;
      end
      if (doWrite && !pop) begin
        count_q <= count_q + 1'b1;
      end else if (pop && !doWrite) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

  // Sticky overflow. If a drop and a clear occur in the same cycle, the drop
  // wins, so that no lost event goes unreported.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      overflow_q <= 1'b0;
    end else if (dropEvent) begin
      overflow_q <= 1'b1;
    end else if (clr_ovf_i) begin
      overflow_q <= 1'b0;
    end
  end

  assign m_axis_tvalid_o = (count_q != '0);
  assign m_axis_tdata_o  = mem_q[rdPtr_q];
  assign overflow_o      = overflow_q;

endmodule

// File: tb/tb_sw_axis.sv
// tb_sw_axis
//
// Directed bench for sw_axis with DEBOUNCE_CYCLES=4 and FIFO_DEPTH=4.
// Inputs change 1 ns after a rising edge. Outputs are sampled at that same
// point, so a value seen after tick N is the result of edge N.

module tb_sw_axis;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic [7:0] sw_i = 8'h00;
  logic       m_axis_tready_i = 1'b1;
  logic       m_axis_tvalid_o;
  logic [7:0] m_axis_tdata_o;
  logic       clr_ovf_i = 1'b0;
  logic       overflow_o;

  int checks = 0;
  int errors = 0;

  sw_axis #(
    .DEBOUNCE_CYCLES(4),
    .FIFO_DEPTH(4)
  ) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .sw_i(sw_i),
    .m_axis_tready_i(m_axis_tready_i),
    .m_axis_tvalid_o(m_axis_tvalid_o),
    .m_axis_tdata_o(m_axis_tdata_o),
    .clr_ovf_i(clr_ovf_i),
    .overflow_o(overflow_o)
  );

  always #5 clk_i = ~clk_i;

  // Advance one rising edge, then settle past it.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;
    checks++;
    if (m_axis_tvalid_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_tvalid got=%b exp=0", m_axis_tvalid_o);
    end
    checks++;
    if (m_axis_tdata_o !== 8'h00) begin
      errors++;
      $display("[TB] FAIL reset_tdata got=%h exp=00", m_axis_tdata_o);
    end
    checks++;
    if (overflow_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_overflow got=%b exp=0", overflow_o);
    end
    rst_i = 1'b0;
    // Zero switches at power-up must never produce an event.
    for (int i = 0; i < 12; i++) begin
      tick();
      checks++;
      if (m_axis_tvalid_o !== 1'b0) begin
        errors++;
        $display("[TB] FAIL powerup_zero_event tick=%0d got=%b exp=0", i, m_axis_tvalid_o);
      end
    end
  endtask

  task automatic test_basic_event();
    m_axis_tready_i = 1'b1;
    sw_i = 8'hA5;
    for (int e = 1; e <= 8; e++) begin
      tick();
      checks++;
      if (m_axis_tvalid_o !== 1'b0) begin
        errors++;
        $display("[TB] FAIL basic_early edge=%0d got=%b exp=0", e, m_axis_tvalid_o);
      end
    end
    tick();
    checks++;
    if (m_axis_tvalid_o !== 1'b1 || m_axis_tdata_o !== 8'hA5) begin
      errors++;
      $display("[TB] FAIL basic_edge9 got=%b/%h exp=1/a5", m_axis_tvalid_o, m_axis_tdata_o);
    end
    tick();
    checks++;
    if (m_axis_tvalid_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL basic_popped got=%b exp=0", m_axis_tvalid_o);
    end
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if (m_axis_tvalid_o !== 1'b0) begin
        errors++;
        $display("[TB] FAIL basic_no_repeat tick=%0d got=%b exp=0", i, m_axis_tvalid_o);
      end
    end
  endtask

  task automatic test_glitch();
    int seen;
    sw_i = 8'h00;
    repeat (12) tick();
    sw_i = 8'h01;
    repeat (3) tick();
    sw_i = 8'h00;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (m_axis_tvalid_o === 1'b1) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("[TB] FAIL glitch_rejected got=%0d events exp=0", seen);
    end
    sw_i = 8'h01;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (m_axis_tvalid_o === 1'b1) begin
        seen++;
        checks++;
        if (m_axis_tdata_o !== 8'h01) begin
          errors++;
          $display("[TB] FAIL glitch_data got=%h exp=01", m_axis_tdata_o);
        end
      end
    end
    checks++;
    if (seen !== 1) begin
      errors++;
      $display("[TB] FAIL glitch_held_count got=%0d exp=1", seen);
    end
  endtask

  task automatic test_backpressure();
    m_axis_tready_i = 1'b0;
    sw_i = 8'h11;
    for (int i = 1; i <= 24; i++) begin
      tick();
      if (i == 8) sw_i = 8'h22;
      checks++;
      if (i < 9) begin
        if (m_axis_tvalid_o !== 1'b0) begin
          errors++;
          $display("[TB] FAIL bp_early tick=%0d got=%b exp=0", i, m_axis_tvalid_o);
        end
      end else if (m_axis_tvalid_o !== 1'b1 || m_axis_tdata_o !== 8'h11) begin
        errors++;
        $display("[TB] FAIL bp_hold tick=%0d got=%b/%h exp=1/11", i, m_axis_tvalid_o, m_axis_tdata_o);
      end
    end
    m_axis_tready_i = 1'b1;
    tick();
    checks++;
    if (m_axis_tvalid_o !== 1'b1 || m_axis_tdata_o !== 8'h22) begin
      errors++;
      $display("[TB] FAIL bp_second got=%b/%h exp=1/22", m_axis_tvalid_o, m_axis_tdata_o);
    end
    tick();
    checks++;
    if (m_axis_tvalid_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL bp_drained got=%b exp=0", m_axis_tvalid_o);
    end
  endtask

  task automatic test_overflow();
    logic [7:0] pats [5];
    logic [7:0] expd [4];
    pats = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    expd = '{8'h02, 8'h03, 8'h04, 8'h00};
    m_axis_tready_i = 1'b0;
    for (int k = 0; k < 5; k++) begin
      sw_i = pats[k];
      repeat (8) tick();
    end
    checks++;
    if (overflow_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL ovf_before_fifth got=%b exp=0", overflow_o);
    end
    repeat (4) tick();
    checks++;
    if (overflow_o !== 1'b1) begin
      errors++;
      $display("[TB] FAIL ovf_set got=%b exp=1", overflow_o);
    end
    checks++;
    if (m_axis_tvalid_o !== 1'b1 || m_axis_tdata_o !== 8'h01) begin
      errors++;
      $display("[TB] FAIL ovf_head got=%b/%h exp=1/01", m_axis_tvalid_o, m_axis_tdata_o);
    end
    m_axis_tready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (m_axis_tvalid_o !== 1'b1 || m_axis_tdata_o !== expd[i]) begin
        errors++;
        $display("[TB] FAIL ovf_drain idx=%0d got=%b/%h exp=1/%h", i, m_axis_tvalid_o, m_axis_tdata_o, expd[i]);
      end
    end
    tick();
    checks++;
    if (m_axis_tvalid_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL ovf_drained got=%b exp=0", m_axis_tvalid_o);
    end
    checks++;
    if (overflow_o !== 1'b1) begin
      errors++;
      $display("[TB] FAIL ovf_sticky got=%b exp=1", overflow_o);
    end
    clr_ovf_i = 1'b1;
    tick();
    clr_ovf_i = 1'b0;
    checks++;
    if (overflow_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL ovf_cleared got=%b exp=0", overflow_o);
    end
  endtask

  task automatic test_full_push_pop();
    logic [7:0] pats [5];
    logic [7:0] expd [4];
    pats = '{8'h51, 8'h52, 8'h53, 8'h54, 8'h55};
    expd = '{8'h52, 8'h53, 8'h54, 8'h55};
    m_axis_tready_i = 1'b0;
    for (int k = 0; k < 5; k++) begin
      sw_i = pats[k];
      repeat (8) tick();
    end
    checks++;
    if (m_axis_tvalid_o !== 1'b1 || m_axis_tdata_o !== 8'h51) begin
      errors++;
      $display("[TB] FAIL full_head got=%b/%h exp=1/51", m_axis_tvalid_o, m_axis_tdata_o);
    end
    // The fifth write lands on the next edge, together with the first pop.
    m_axis_tready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (m_axis_tvalid_o !== 1'b1 || m_axis_tdata_o !== expd[i]) begin
        errors++;
        $display("[TB] FAIL full_order idx=%0d got=%b/%h exp=1/%h", i, m_axis_tvalid_o, m_axis_tdata_o, expd[i]);
      end
    end
    tick();
    checks++;
    if (m_axis_tvalid_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL full_drained got=%b exp=0", m_axis_tvalid_o);
    end
    checks++;
    if (overflow_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL full_no_overflow got=%b exp=0", overflow_o);
    end
  endtask

  task automatic test_reset_midstream();
    int seen;
    m_axis_tready_i = 1'b0;
    sw_i = 8'h61;
    repeat (8) tick();
    sw_i = 8'h62;
    repeat (12) tick();
    checks++;
    if (m_axis_tvalid_o !== 1'b1 || m_axis_tdata_o !== 8'h61) begin
      errors++;
      $display("[TB] FAIL mid_queued got=%b/%h exp=1/61", m_axis_tvalid_o, m_axis_tdata_o);
    end
    sw_i = 8'h3C;
    rst_i = 1'b1;
    #1;
    checks++;
    if (m_axis_tvalid_o !== 1'b0 || overflow_o !== 1'b0 || m_axis_tdata_o !== 8'h00) begin
      errors++;
      $display("[TB] FAIL mid_async_clear got=%b/%b/%h exp=0/0/00", m_axis_tvalid_o, overflow_o, m_axis_tdata_o);
    end
    tick();
    rst_i = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      tick();
      checks++;
      if (m_axis_tvalid_o !== 1'b0) begin
        errors++;
        $display("[TB] FAIL mid_early edge=%0d got=%b exp=0", e, m_axis_tvalid_o);
      end
    end
    tick();
    checks++;
    if (m_axis_tvalid_o !== 1'b1 || m_axis_tdata_o !== 8'h3C) begin
      errors++;
      $display("[TB] FAIL mid_event got=%b/%h exp=1/3c", m_axis_tvalid_o, m_axis_tdata_o);
    end
    m_axis_tready_i = 1'b1;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (m_axis_tvalid_o === 1'b1) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("[TB] FAIL mid_single_event got=%0d extra exp=0", seen);
    end
  endtask

  initial begin
    test_reset();
    test_basic_event();
    test_glitch();
    test_backpressure();
    test_overflow();
    test_full_push_pop();
    test_reset_midstream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sw_axis.md
# sw_axis

Debounces the 8 board slide switches and publishes each new stable switch pattern as one byte on an AXI-Stream master port. Sits directly upstream of the SoC's AXI-Stream/CPU interface core (`if_axis`), alongside the PS/2 keyboard source, so software reads switch events through the same stream path. A 4-entry output FIFO holds events while the consumer is busy; events that arrive when the FIFO is full are dropped and flagged.

## Interface
- `DEBOUNCE_CYCLES`, default 500000: number of clock cycles (10 ms at 50 MHz) a new input pattern must hold unchanged before it is accepted. Must be ≥ 2.
- `FIFO_DEPTH`, default 4: output FIFO entries. Must be a power of 2 and ≥ 2.
- `clk_i` in, 1: system clock (50 MHz SoC clock). Reset `rst_i` is asynchronous and active-high; the clock is `clk_i`.
- `rst_i` in, 1: asynchronous, active-high reset.
- `sw_i` in, 8: raw switch inputs, asynchronous to `clk_i`.
- `m_axis_tready_i` in, 1: consumer ready.
- `m_axis_tvalid_o` out, 1: FIFO head is valid.
- `m_axis_tdata_o` out, 8: FIFO head byte (switch pattern).
- `clr_ovf_i` in, 1: synchronous clear of `overflow_o`.
- `overflow_o` out, 1: sticky flag, set when an event is dropped.

## Operation
- **Synchronizer.** `sw_i` passes through a 2-FF synchronizer (`sync1`, then `sync2`). Reset value is 0x00.
- **Debounce.** The block holds `cand` (8 bits), `cnt` (width `$clog2(DEBOUNCE_CYCLES)`), and `stable` (8 bits). All three reset to 0.
  - If `sync2 != cand`: load `cand <= sync2` and `cnt <= 0`.
  - Else if `cnt == DEBOUNCE_CYCLES-1`: load `stable <= cand`, and `cnt` holds.
  - Else: `cnt <= cnt + 1`.
  - Any change in any bit restarts the count for the whole byte.
- **Change detect.** `push` is a registered pulse, asserted for one cycle when `stable` takes a value different from its previous value. A pulse that returns to the old pattern before acceptance produces no event.
- **Power-up.** `stable` resets to 0x00. If the switches are non-zero at reset release, their pattern is emitted once it settles. All-zero switches produce no event.
- **FIFO.** Pointers wrap modulo `FIFO_DEPTH`. `count` spans 0..`FIFO_DEPTH`. `pop = m_axis_tvalid_o & m_axis_tready_i`.
  - `push` while not full: write the entry.
  - `push` while full with no `pop`: discard the byte and set `overflow_o`.
  - `push` and `pop` in the same cycle while full: accept the push; `count` stays at `FIFO_DEPTH`.
  - `push` and `pop` in the same cycle while empty cannot occur, because `tvalid` is low.
- **AXIS.** `m_axis_tvalid_o = (count != 0)`. `m_axis_tdata_o` is the head entry. While `tvalid & ~tready`, `tdata` holds stable and `tvalid` stays high; an entry is never withdrawn.
- **Overflow.** `overflow_o` clears on `clr_ovf_i`. If the set and clear conditions occur in the same cycle, set wins.

## Timing
- **Reset values.** `m_axis_tvalid_o = 0`, `m_axis_tdata_o = 0x00`, `overflow_o = 0`. FIFO is empty, and `sync1`, `sync2`, `cand`, `cnt`, `stable` are all 0.
- **Reset mid-operation.** All state clears immediately. Queued events are lost, and `tvalid` drops asynchronously.
- **Latency, edge by edge.** Let edge 1 be the first edge that samples the new `sw_i`, with `sw_i` held steady afterwards.
  - Edge 2: `sync2` updates.
  - Edge 3: `cand` loads and `cnt` = 0.
  - Edge 2+`DEBOUNCE_CYCLES`: `cnt` = `DEBOUNCE_CYCLES-1`.
  - Edge 3+`DEBOUNCE_CYCLES`: `stable` updates.
  - Edge 4+`DEBOUNCE_CYCLES`: `push` is registered.
  - Edge 5+`DEBOUNCE_CYCLES`: FIFO write; `m_axis_tvalid_o` is high after this edge.
- **Minimum spacing between events** is `DEBOUNCE_CYCLES`+1 cycles.
- **Throughput.** With `tready` held high, one entry is popped per cycle. A popped entry leaves the FIFO on the edge where `tvalid & tready` is sampled high.

## Test plan
Benches use `DEBOUNCE_CYCLES`=4 and `FIFO_DEPTH`=4.
- **Basic event.** Reset, with `tready`=1 and `sw_i`=0x00. Set `sw_i`=0xA5 before edge 1 -> `tvalid` rises after edge 9 with `tdata`=0xA5 and falls after one cycle. No further events follow.
- **Glitch rejection.** `sw_i`=0x00 -> 0x01 for 3 cycles -> 0x00 -> no `tvalid` within 20 cycles. Then `sw_i`=0x01 held for 10 cycles -> exactly one event with `tdata`=0x01.
- **Backpressure hold.** `tready`=0. Apply 0x11, then 0x22, each held for 8 cycles -> `tvalid` stays high and `tdata` stays 0x11 throughout. Raise `tready` -> 0x11 is accepted, then 0x22 on the next cycle, then `tvalid`=0.
- **Overflow.** `tready`=0. Apply 5 distinct patterns (0x01, 0x02, 0x03, 0x04, 0x05) -> FIFO holds 0x01..0x04 and `overflow_o`=1. Drain -> output order is 0x01, 0x02, 0x03, 0x04. Pulse `clr_ovf_i` -> `overflow_o`=0.
- **Full with simultaneous push and pop.** Fill to 4 entries, then assert `tready` on the same edge as the 5th push (0x55) -> no overflow, `count` stays 4, and 0x55 is eventually output fifth.
- **Reset mid-stream.** With 2 entries queued, pulse `rst_i` -> `tvalid`=0 and `overflow_o`=0 immediately. With `sw_i`=0x3C held -> a single 0x3C event appears 9 edges after reset release.
